// File: rtl/rst_seq_pkg.sv
// Shared definitions for the global reset sequencer: phase encoding and default counter width.
package rst_seq_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] PH_PRE     = 2'd0;
  localparam logic [1:0] PH_ASSERT  = 2'd1;
  localparam logic [1:0] PH_RELEASE = 2'd2;
  localparam logic [1:0] PH_DONE    = 2'd3;

endpackage

// File: rtl/rst_seq_cnt.sv
// Phase counter: synchronous clear, enable, saturates at all-ones, terminal-count compare.
module rst_seq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             i_local_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en && (o_cnt != '1)) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (o_cnt == i_tc_val);

endmodule

// File: rtl/rst_seq_gen.sv
// Global reset sequencer: PRE hold-high, ASSERT window, staggered per-channel release, DONE.
// Optional soft re-sequence from RELEASE/DONE enabled by defining RST_SEQ_SOFT_EN.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int          N_CH       = 4,
  parameter int unsigned PRE_DLY    = 32'h8000,
  parameter int unsigned ASSERT_LEN = 32'h7FFF,
  parameter int unsigned STAGE_DLY  = 16
) (
  input  logic            i_local_clk,
  input  logic            i_rst_n,
  input  logic            i_soft_req,
  output logic [N_CH-1:0] o_rst_n,
  output logic            o_done,
  output logic [1:0]      o_phase
);

  if (N_CH < 1) begin : g_chk_nch
    $error("rst_seq_gen: N_CH must be >= 1");
  end
  if ((ASSERT_LEN < 1) || (STAGE_DLY < 1)) begin : g_chk_min
    $error("rst_seq_gen: ASSERT_LEN and STAGE_DLY must be >= 1");
  end
  if (((PRE_DLY >> CNT_W) != 0) || ((ASSERT_LEN >> CNT_W) != 0) ||
      ((STAGE_DLY >> CNT_W) != 0)) begin : g_chk_fit
    $error("rst_seq_gen: delay parameters must fit in CNT_W bits");
  end

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((N_CH > 1) ? N_CH - 2 : 0);
  localparam logic [N_CH-1:0]  CH0       = N_CH'(1);
  localparam logic [CNT_W-1:0] TC_PRE    = CNT_W'(PRE_DLY);
  localparam logic [CNT_W-1:0] TC_ASSERT = CNT_W'(ASSERT_LEN - 1);
  localparam logic [CNT_W-1:0] TC_STAGE  = CNT_W'(STAGE_DLY - 1);

  logic [1:0]       phase_d;
  logic [N_CH-1:0]  rst_d;
  logic             done_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             cnt_clr, cnt_en, cnt_tc, soft_hit;
  logic [CNT_W-1:0] tc_val;
  logic [CNT_W-1:0] cnt;

  rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_local_clk (i_local_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (cnt_clr),
    .i_en        (cnt_en),
    .i_tc_val    (tc_val),
    .o_cnt       (cnt),
    .o_tc        (cnt_tc)
  );

`ifdef RST_SEQ_SOFT_EN
  assign soft_hit = i_soft_req && ((o_phase == PH_RELEASE) || (o_phase == PH_DONE));
`else
  logic unused_soft_req;
  assign unused_soft_req = i_soft_req;
  assign soft_hit        = 1'b0;
`endif

  always_comb begin
    tc_val = TC_STAGE;
    case (o_phase)
      PH_PRE:    tc_val = TC_PRE;
      PH_ASSERT: tc_val = TC_ASSERT;
      default:   tc_val = TC_STAGE;
    endcase
  end

  // Phase register; o_phase is the FSM state itself.
  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_phase <= PH_PRE;
      o_rst_n <= '0;
      o_done  <= 1'b0;
      idx     <= '0;
    end else begin
      o_phase <= phase_d;
      o_rst_n <= rst_d;
      o_done  <= done_d;
      idx     <= idx_d;
    end
  end

  // Next phase; a soft request outranks a simultaneous last-channel release.
  always_comb begin
    phase_d = o_phase;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (soft_hit) begin
      phase_d = PH_ASSERT;
      cnt_clr = 1'b1;
    end else begin
      case (o_phase)
        PH_PRE: begin
          if (cnt_tc) begin
            phase_d = PH_ASSERT;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        PH_ASSERT: begin
          if (cnt_tc) begin
            phase_d = (N_CH == 1) ? PH_DONE : PH_RELEASE;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        PH_RELEASE: begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            if (idx == LAST_IDX) phase_d = PH_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Channels release as a thermometer: each stage shifts in one more high bit.
  always_comb begin
    rst_d  = o_rst_n;
    idx_d  = idx;
    done_d = (phase_d == PH_DONE);
    if (phase_d == PH_ASSERT) begin
      rst_d = '0;
      idx_d = '0;
    end else if (o_phase == PH_PRE) begin
      rst_d = '1;
    end else if (cnt_clr) begin
      rst_d = (o_rst_n << 1) | CH0;
      if (o_phase == PH_RELEASE) idx_d = idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: three instances (main, zero pre-delay, single channel) against a timeline model.
module tb_rst_seq_gen;

  localparam int AL = 8;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_a = 1'b0;
  logic [3:0] rst_a, rst_b;
  logic [0:0] rst_c;
  logic       done_a, done_b, done_c;
  logic [1:0] ph_a, ph_b, ph_c;

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;
  int oa       = 1;
  int pa       = 4;
  int ob       = 1;
  bit in_rst   = 1'b1;
  int soft_plan[$];

  always #5 clk = ~clk;

  rst_seq_gen #(.CNT_W(16), .N_CH(4), .PRE_DLY(4), .ASSERT_LEN(AL), .STAGE_DLY(SD)) u_dut_a (
    .i_local_clk(clk), .i_rst_n(rst_n), .i_soft_req(soft_a),
    .o_rst_n(rst_a), .o_done(done_a), .o_phase(ph_a)
  );
  rst_seq_gen #(.CNT_W(16), .N_CH(4), .PRE_DLY(0), .ASSERT_LEN(AL), .STAGE_DLY(SD)) u_dut_b (
    .i_local_clk(clk), .i_rst_n(rst_n), .i_soft_req(1'b0),
    .o_rst_n(rst_b), .o_done(done_b), .o_phase(ph_b)
  );
  rst_seq_gen #(.CNT_W(16), .N_CH(1), .PRE_DLY(4), .ASSERT_LEN(AL), .STAGE_DLY(SD)) u_dut_c (
    .i_local_clk(clk), .i_rst_n(rst_n), .i_soft_req(1'b0),
    .o_rst_n(rst_c), .o_done(done_c), .o_phase(ph_c)
  );

  // Timeline model: r is the edge number since the sequence origin (0 = held in reset).
  task automatic model(input int r, input int pre, input int n,
                       output logic [3:0] rst, output logic done, output logic [1:0] ph);
    int t0, last;
    rst = '0; done = 1'b0; ph = 2'd0;
    if (r <= 0) return;
    if (r <= pre) begin
      for (int k = 0; k < n; k++) rst[k] = 1'b1;
      return;
    end
    t0   = pre + AL + 1;
    last = t0 + (n - 1) * SD;
    for (int k = 0; k < n; k++) rst[k] = (r >= t0 + k * SD);
    done = (r >= last);
    ph   = (r < t0) ? 2'd1 : ((r < last) ? 2'd2 : 2'd3);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
    end
  endtask

  task automatic check_all();
    logic [3:0] xr;
    logic       xd;
    logic [1:0] xp;
    model(in_rst ? 0 : e - oa + 1, pa, 4, xr, xd, xp);
    chk("a_rst_n", {4'h0, rst_a}, {4'h0, xr});
    chk("a_done", {7'h0, done_a}, {7'h0, xd});
    chk("a_phase", {6'h0, ph_a}, {6'h0, xp});
    model(in_rst ? 0 : e - ob + 1, 0, 4, xr, xd, xp);
    chk("b_rst_n", {4'h0, rst_b}, {4'h0, xr});
    chk("b_done", {7'h0, done_b}, {7'h0, xd});
    chk("b_phase", {6'h0, ph_b}, {6'h0, xp});
    model(in_rst ? 0 : e - ob + 1, 4, 1, xr, xd, xp);
    chk("c_rst_n", {7'h0, rst_c}, {7'h0, xr[0]});
    chk("c_done", {7'h0, done_c}, {7'h0, xd});
    chk("c_phase", {6'h0, ph_c}, {6'h0, xp});
  endtask

  // One clock edge; s drives i_soft_req so that it is sampled at this edge.
  task automatic step(input bit s);
    logic [3:0] pr;
    logic       pd;
    logic [1:0] pp;
    soft_a = s;
    @(posedge clk);
    e++;
`ifdef RST_SEQ_SOFT_EN
    if (s) begin
      model(e - oa, pa, 4, pr, pd, pp);
      if ((pp == 2'd2) || (pp == 2'd3)) begin
        oa = e;
        pa = 0;
      end
    end
`else
    pr = '0; pd = 1'b0; pp = '0;
`endif
    #1;
    soft_a = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    soft_a = 1'b0;
    in_rst = 1'b1;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n  = 1'b1;
    in_rst = 1'b0;
    e  = 0;
    oa = 1;
    pa = 4;
    ob = 1;
  endtask

  task automatic run(input int upto);
    bit s;
    while (e < upto) begin
      s = 1'b0;
      foreach (soft_plan[i]) if (soft_plan[i] == e + 1) s = 1'b1;
      step(s);
    end
  endtask

  initial begin
    // Full sequence with ignored pulses in PRE/ASSERT, a DONE pulse and a RELEASE pulse.
    do_reset();
    soft_plan = '{6, 0, 30, 0};
    soft_plan[1] = int'($urandom_range(1, 12));
    soft_plan[3] = int'($urandom_range(40, 47));
    run(70);

    // Reset mid-sequence, then a clean rerun.
    soft_plan.delete();
    do_reset();
    run(15);
    do_reset();
    run(40);

    // Random soft pulses, each round cut short by the next reset.
    for (int it = 0; it < 4; it++) begin
      int len;
      do_reset();
      len = int'($urandom_range(20, 60));
      for (int k = 0; k < len; k++) step($urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
